// File: rtl/paint_pkg.sv
// Shared definitions for the paint-mixing scheduler: colour ids, FSM states,
// round-count width and the colour -> per-primary round recipe.
package paint_pkg;

  localparam int FREQ_W = 10;

  typedef enum logic [2:0] {
    COL_RED     = 3'd0,
    COL_YELLOW  = 3'd1,
    COL_BLUE    = 3'd2,
    COL_ORANGE  = 3'd3,
    COL_GREEN   = 3'd4,
    COL_PURPLE  = 3'd5,
    COL_BROWN   = 3'd6,
    COL_INVALID = 3'd7
  } color_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_COOL  = 3'd4
  } state_e;

  typedef struct packed {
    logic [FREQ_W-1:0] r;
    logic [FREQ_W-1:0] y;
    logic [FREQ_W-1:0] b;
  } recipe_t;

  // Primaries get the full round count; mixes get half per component, never zero.
  function automatic recipe_t recipe(input logic [2:0] color, input int rounds);
    logic [FREQ_W-1:0] p;
    logic [FREQ_W-1:0] s;
    recipe_t           rc;
    p  = FREQ_W'(rounds);
    s  = (rounds / 2 > 0) ? FREQ_W'(rounds / 2) : FREQ_W'(1);
    rc = '0;
    case (color)
      COL_RED:    rc.r = p;
      COL_YELLOW: rc.y = p;
      COL_BLUE:   rc.b = p;
      COL_ORANGE: begin rc.r = s; rc.y = s; end
      COL_GREEN:  begin rc.y = s; rc.b = s; end
      COL_PURPLE: begin rc.r = s; rc.b = s; end
      COL_BROWN:  begin rc.r = s; rc.y = s; rc.b = s; end
      default:    rc = '0;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/paint_job_scheduler_if.sv
// Order and sequencer handshake bundle of the paint job scheduler.
// master = UI / sequencer side, slave = scheduler.
interface paint_job_scheduler_if;
  import paint_pkg::*;

  logic              order_valid;
  logic [2:0]        order_color;
  logic              order_ready;
  logic              job_done;
  logic              job_start;
  logic              job_active;
  logic [FREQ_W-1:0] freq_for_red;
  logic [FREQ_W-1:0] freq_for_yellow;
  logic [FREQ_W-1:0] freq_for_blue;
  logic [2:0]        queue_count;
  logic [3:0]        reject_cnt;
  logic              err_timeout;

  modport master (
    output order_valid, order_color, job_done,
    input  order_ready, job_start, job_active,
           freq_for_red, freq_for_yellow, freq_for_blue,
           queue_count, reject_cnt, err_timeout
  );

  modport slave (
    input  order_valid, order_color, job_done,
    output order_ready, job_start, job_active,
           freq_for_red, freq_for_yellow, freq_for_blue,
           queue_count, reject_cnt, err_timeout
  );
endinterface

// File: rtl/order_fifo.sv
// Circular order FIFO with extra-MSB pointers; head is visible combinationally
// so the consumer can use it on the same tick it pops.
module order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk_cnt,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_cnt) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Pointer advance; push and pop together leave the occupancy unchanged.
  always_ff @(posedge clk_cnt or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/paint_job_scheduler.sv
// Paint job scheduler: queues colour orders, converts each into per-primary
// round counts and runs one start/done handshake per order with the stepper
// sequencer, with a done timeout and an idle gap between jobs.
module paint_job_scheduler
  import paint_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 600,
  parameter int GAP     = 3,
  parameter int ROUNDS  = 2
) (
  input logic                  clk_cnt,
  input logic                  rst,
  paint_job_scheduler_if.slave bus
);
  localparam int             TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT - 1);
  localparam int             GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]  GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam int             CW       = $clog2(QDEPTH) + 1;

  state_e            state_q;
  logic [TW-1:0]     tmr_q;
  logic [GW-1:0]     gap_q;
  logic [FREQ_W-1:0] freq_r_q;
  logic [FREQ_W-1:0] freq_y_q;
  logic [FREQ_W-1:0] freq_b_q;
  logic              job_start_q;
  logic              job_active_q;
  logic              err_q;
  logic [3:0]        reject_q;
  logic [3:0]        reject_d;
  logic              rdy_en_q;

  logic              order_ready;
  logic              accept;
  logic              is_invalid;
  logic              fifo_push;
  logic              fifo_pop;
  logic [2:0]        fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  recipe_t           head_rc;

  // Ready is held low through reset and comes up on the first edge after it.
  assign order_ready = rdy_en_q && !fifo_full;
  assign accept      = bus.order_valid && order_ready;
  assign is_invalid  = (bus.order_color == COL_INVALID);
  assign fifo_push   = accept && !is_invalid;
  assign fifo_pop    = (state_q == ST_LOAD);
  assign head_rc     = recipe(fifo_head, ROUNDS);
  assign reject_d    = (accept && is_invalid && reject_q != 4'hF) ? reject_q + 4'd1 : reject_q;

  order_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk_cnt (clk_cnt),
    .rst     (rst),
    .push    (fifo_push),
    .din     (bus.order_color),
    .pop     (fifo_pop),
    .dout    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Ready enable: low while in reset, high from the first clock afterwards.
  always_ff @(posedge clk_cnt or posedge rst) begin
    if (rst) rdy_en_q <= 1'b0;
    else     rdy_en_q <= 1'b1;
  end

  // Saturating count of invalid orders that were taken and dropped.
  always_ff @(posedge clk_cnt or posedge rst) begin
    if (rst) reject_q <= '0;
    else     reject_q <= reject_d;
  end

  // Job sequencing FSM with registered handshake and recipe outputs.
  always_ff @(posedge clk_cnt or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      gap_q        <= '0;
      freq_r_q     <= '0;
      freq_y_q     <= '0;
      freq_b_q     <= '0;
      job_start_q  <= 1'b0;
      job_active_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      job_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          freq_r_q <= head_rc.r;
          freq_y_q <= head_rc.y;
          freq_b_q <= head_rc.b;
          state_q  <= ST_START;
        end
        ST_START: begin
          job_start_q  <= 1'b1;
          job_active_q <= 1'b1;
          tmr_q        <= '0;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done on the final timeout tick wins over the timeout.
          if (bus.job_done) begin
            job_active_q <= 1'b0;
            gap_q        <= '0;
            state_q      <= (GAP == 0) ? ST_IDLE : ST_COOL;
          end else if (tmr_q == TMR_LAST) begin
            err_q        <= 1'b1;
            job_active_q <= 1'b0;
            gap_q        <= '0;
            state_q      <= (GAP == 0) ? ST_IDLE : ST_COOL;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_COOL: begin
          if (gap_q == GAP_LAST) state_q <= ST_IDLE;
          else                   gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.order_ready     = order_ready;
  assign bus.job_start       = job_start_q;
  assign bus.job_active      = job_active_q;
  assign bus.freq_for_red    = freq_r_q;
  assign bus.freq_for_yellow = freq_y_q;
  assign bus.freq_for_blue   = freq_b_q;
  assign bus.queue_count     = 3'(fifo_count);
  assign bus.reject_cnt      = reject_q;
  assign bus.err_timeout     = err_q;
endmodule
